// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, grant codes
// and the fixed/starvation-aware priority pick.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_MEM  = 2'b10;

  // Data wins a tie unless fetch_first says fetch has waited long enough.
  function automatic logic [1:0] arb_pick(input logic if_req_i,
                                          input logic mem_req_i,
                                          input logic fetch_first_i);
    logic [1:0] pick;
    if (if_req_i && (fetch_first_i || !mem_req_i)) begin
      pick = GNT_IF;
    end else if (mem_req_i) begin
      pick = GNT_MEM;
    end else begin
      pick = GNT_NONE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port RAM with fixed read latency.
// Optional fetch starvation guard compiled in with ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  output logic        ram_write_enable,
  input  logic [31:0] ram_data_out,
  output logic        busy,
  output logic [1:0]  grant
);

  localparam logic [2:0] CNT_LOAD = 3'(RAM_LATENCY - 1);

  if (RAM_LATENCY < 1 || RAM_LATENCY > 7 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_param_check
    $error("mem_arbiter: parameter out of range");
  end

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  cnt_r;
  logic [1:0]  grant_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] if_rdata_r;
  logic [31:0] mem_rdata_r;
  logic        we_flag_r;
  logic        we_strobe_r;
  logic        if_ready_r;
  logic        mem_ready_r;
  logic        busy_r;
  logic        fetch_first_s;
  logic [1:0]  winner_s;
  logic        grant_load_s;
  logic        capture_s;
  logic        release_s;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_r;

  // Starve counter: data grants made while fetch waits; any fetch grant clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_r <= 4'd0;
    end else if (grant_load_s && (winner_s == GNT_IF)) begin
      starve_r <= 4'd0;
    end else if (grant_load_s && if_req && (starve_r != 4'hF)) begin
      starve_r <= starve_r + 4'd1;
    end
  end

  // Fetch takes priority once the data side has used up its allowance.
  always_comb begin
    fetch_first_s = (starve_r == 4'(STARVE_LIMIT));
  end
`else
  // Fixed priority: data always first.
  always_comb begin
    fetch_first_s = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (winner_s != GNT_NONE) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/control decode: when to grant, when to capture RAM data, when to release.
  always_comb begin
    winner_s     = arb_pick(if_req, mem_req, fetch_first_s);
    grant_load_s = 1'b0;
    capture_s    = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      ST_IDLE:   grant_load_s = (winner_s != GNT_NONE);
      ST_ACCESS: capture_s    = (cnt_r == 3'd0);
      ST_RESP:   release_s    = 1'b1;
      default: begin
        grant_load_s = 1'b0;
        capture_s    = 1'b0;
        release_s    = 1'b0;
      end
    endcase
  end

  // Transaction datapath: latch winner, count latency, capture read data, pulse ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= 3'd0;
      grant_r     <= GNT_NONE;
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      we_flag_r   <= 1'b0;
      we_strobe_r <= 1'b0;
      busy_r      <= 1'b0;
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      if_rdata_r  <= 32'd0;
      mem_rdata_r <= 32'd0;
    end else begin
      we_strobe_r <= 1'b0;
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      if (grant_load_s) begin
        grant_r <= winner_s;
        busy_r  <= 1'b1;
        cnt_r   <= CNT_LOAD;
        if (winner_s == GNT_MEM) begin
          addr_r      <= mem_addr;
          wdata_r     <= mem_wdata;
          we_flag_r   <= mem_we;
          we_strobe_r <= mem_we;
        end else begin
          addr_r    <= if_addr;
          wdata_r   <= 32'd0;
          we_flag_r <= 1'b0;
        end
      end else if (capture_s) begin
        if (grant_r == GNT_IF) begin
          if_rdata_r <= ram_data_out;
          if_ready_r <= 1'b1;
        end else begin
          // A write completes with a ready pulse but leaves read data untouched.
          if (!we_flag_r) begin
            mem_rdata_r <= ram_data_out;
          end
          mem_ready_r <= 1'b1;
        end
      end else if (state_r == ST_ACCESS) begin
        cnt_r <= cnt_r - 3'd1;
      end else if (release_s) begin
        grant_r   <= GNT_NONE;
        busy_r    <= 1'b0;
        addr_r    <= 32'd0;
        wdata_r   <= 32'd0;
        we_flag_r <= 1'b0;
      end
    end
  end

  assign if_ready         = if_ready_r;
  assign if_rdata         = if_rdata_r;
  assign mem_ready        = mem_ready_r;
  assign mem_rdata        = mem_rdata_r;
  assign ram_address      = addr_r;
  assign ram_data_in      = wdata_r;
  assign ram_write_enable = we_strobe_r;
  assign busy             = busy_r;
  assign grant            = grant_r;

endmodule
